// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the sequence pattern generator.
//   state_e   : IDLE / RUN / DONE encodings
//   drive_t   : registered bundle driven toward the detector ({x2,x1}, valid, busy, done)
//   pat_entry : extracts table entry idx from the packed 2-bit-per-entry pattern
package seq_pattern_gen_pkg;

    localparam int unsigned IDX_W             = 3;
    localparam int unsigned ZCNT_W            = 8;
    localparam int unsigned CODE_W            = 2;
    localparam int unsigned PAT_W             = 16;
    localparam int unsigned DB_CYCLES_DEFAULT = 2_000_000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              valid;
        logic              busy;
        logic              done;
    } drive_t;

    // Entry i occupies PATTERN[2i+1:2i] = {x2,x1}.
    function automatic logic [CODE_W-1:0] pat_entry(input logic [PAT_W-1:0] pat,
                                                    input logic [IDX_W-1:0] idx);
        return pat[{idx, 1'b0} +: CODE_W];
    endfunction

endpackage

// File: rtl/seq_pattern_gen_sync_edge.sv
// 2-flop synchronizer, optional debounce and registered rising-edge pulse.
//   clk, rst_n : clock, async active-low reset
//   din        : asynchronous input level
//   pe         : one-clock pulse, 3 clocks after a din rise (plus DB_CYCLES when debounced)
// DEBOUNCE_EN is set by the top from the SEQ_GEN_DEBOUNCE_EN macro for the start input only.
module seq_pattern_gen_sync_edge
    import seq_pattern_gen_pkg::*;
#(
    parameter bit          DEBOUNCE_EN = 1'b0,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pe
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic pe_q,   pe_d;
    logic lvl_c;

    generate
        if (DEBOUNCE_EN) begin : g_db
            localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             lvl_q, lvl_d;

            // Level follows the synchronized input only after DB_CYCLES consecutive disagreeing samples.
            always_comb begin
                cnt_d = cnt_q;
                lvl_d = lvl_q;
                if (sync_q == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d = sync_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign lvl_c = lvl_q;
        end else begin : g_nodb
            assign lvl_c = sync_q;
        end
    endgenerate

    // Synchronizer chain and edge detector on the (possibly debounced) level.
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = lvl_c;
        pe_d   = lvl_c & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            pe_q   <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            pe_q   <= pe_d;
        end
    end

    assign pe = pe_q;

endmodule

// File: rtl/seq_pattern_gen.sv
// Steps a programmable table of 2-bit codes onto (x2,x1) of a detector under test,
// one code per STEP_DIV clocks, and counts detector z rising edges during a run.
//   sys_clk_in, sys_rst_n : clock, async active-low reset (released synchronously)
//   start                 : raw button, rising edge starts / restarts a run
//   mode_loop             : 1 = wrap after last entry, 0 = single pass (sampled at each tick)
//   z_in                  : asynchronous detector output
//   x2, x1, valid         : driven code and its qualifier
//   busy, done            : RUN / DONE status
//   step_idx, z_count     : current table index, saturating z edge count
// Build option: SEQ_GEN_DEBOUNCE_EN debounces start over DB_CYCLES clocks.
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int unsigned      STEP_DIV  = 50_000_000,
    parameter int unsigned      DEPTH     = 8,
    parameter logic [PAT_W-1:0] PATTERN   = 16'h1B1B,
    parameter int unsigned      DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic              sys_clk_in,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              mode_loop,
    input  logic              z_in,
    output logic              x2,
    output logic              x1,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  step_idx,
    output logic [ZCNT_W-1:0] z_count
);

`ifdef SEQ_GEN_DEBOUNCE_EN
    localparam bit START_DB_EN = 1'b1;
`else
    localparam bit START_DB_EN = 1'b0;
`endif

    localparam int unsigned      PS_W     = $clog2(STEP_DIV);
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(STEP_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    // Reset synchronizer: assertion is immediate, release aligned to the clock.
    logic rst_meta_q, rst_sync_q;
    logic rst_n_i;

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n_i = rst_sync_q;

    logic start_pe;
    logic z_pe;

    seq_pattern_gen_sync_edge #(
        .DEBOUNCE_EN (START_DB_EN),
        .DB_CYCLES   (DB_CYCLES)
    ) u_start_edge (
        .clk   (sys_clk_in),
        .rst_n (rst_n_i),
        .din   (start),
        .pe    (start_pe)
    );

    seq_pattern_gen_sync_edge #(
        .DEBOUNCE_EN (1'b0),
        .DB_CYCLES   (DB_CYCLES)
    ) u_z_edge (
        .clk   (sys_clk_in),
        .rst_n (rst_n_i),
        .din   (z_in),
        .pe    (z_pe)
    );

    state_e            state_q, state_d;
    logic [PS_W-1:0]   ps_q,    ps_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [ZCNT_W-1:0] zcnt_q,  zcnt_d;
    drive_t            drv_q,   drv_d;
    logic              tick_c;
    logic [IDX_W-1:0]  idx_nxt_c;

    // Next-state: (re)start has priority over everything, including a tick.
    always_comb begin
        state_d   = state_q;
        ps_d      = ps_q;
        idx_d     = idx_q;
        zcnt_d    = zcnt_q;
        drv_d     = drv_q;
        tick_c    = (state_q == ST_RUN) && (ps_q == PS_LAST);
        idx_nxt_c = idx_q + IDX_W'(1);

        if (start_pe) begin
            state_d = ST_RUN;
            ps_d    = '0;
            idx_d   = '0;
            zcnt_d  = '0;
            drv_d   = '{code: pat_entry(PATTERN, '0), valid: 1'b1, busy: 1'b1, done: 1'b0};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (z_pe && (zcnt_q != {ZCNT_W{1'b1}})) begin
                        zcnt_d = zcnt_q + ZCNT_W'(1);
                    end
                    if (tick_c) begin
                        ps_d = '0;
                        if (idx_q != IDX_LAST) begin
                            idx_d      = idx_nxt_c;
                            drv_d.code = pat_entry(PATTERN, idx_nxt_c);
                        end else if (mode_loop) begin
                            idx_d      = '0;
                            drv_d.code = pat_entry(PATTERN, '0);
                        end else begin
                            // step_idx keeps the last index while in DONE
                            state_d = ST_DONE;
                            drv_d   = '{code: CODE_W'(0), valid: 1'b0, busy: 1'b0, done: 1'b1};
                        end
                    end else begin
                        ps_d = ps_q + PS_W'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk_in or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ps_q    <= '0;
            idx_q   <= '0;
            zcnt_q  <= '0;
            drv_q   <= '0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            zcnt_q  <= zcnt_d;
            drv_q   <= drv_d;
        end
    end

    assign x2       = drv_q.code[1];
    assign x1       = drv_q.code[0];
    assign valid    = drv_q.valid;
    assign busy     = drv_q.busy;
    assign done     = drv_q.done;
    assign step_idx = idx_q;
    assign z_count  = zcnt_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected output tuples and their hold
// lengths are queued as stimulus is applied and checked on every output change.
module tb_seq_pattern_gen;

    localparam int unsigned STEP_DIV    = 4;
    localparam int unsigned DEPTH       = 4;
    localparam logic [15:0] PATTERN     = 16'h00E4;
    localparam int unsigned DB_CYCLES   = 8;
    localparam int          LOOP_PASSES = 80;
`ifdef SEQ_GEN_DEBOUNCE_EN
    localparam int START_LAT = 3 + DB_CYCLES;
    localparam int PRESS     = 12;
`else
    localparam int START_LAT = 3;
    localparam int PRESS     = 2;
`endif

    logic       clk = 1'b0;
    logic       sys_rst_n, start, mode_loop, z_in;
    logic       x2, x1, valid, busy, done;
    logic [2:0] step_idx;
    logic [7:0] z_count;

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .STEP_DIV  (STEP_DIV),
        .DEPTH     (DEPTH),
        .PATTERN   (PATTERN),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .sys_clk_in (clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .mode_loop  (mode_loop),
        .z_in       (z_in),
        .x2         (x2),
        .x1         (x1),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx),
        .z_count    (z_count)
    );

    typedef struct {
        logic [7:0] tup;
        int         hold;
    } sb_item_t;

    sb_item_t   sb_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_push   = 0;
    int         n_pop    = 0;
    logic       mon_en   = 1'b0;
    logic [7:0] last_tup = '0;
    int         held     = 0;
    int         held_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] model_code(input int idx);
        logic [15:0] p;
        p = PATTERN;
        return p[2*idx +: 2];
    endfunction

    function automatic void push_run(input int idx, input int hold);
        sb_item_t it;
        it.tup = {model_code(idx), 3'b110, 3'(idx)};
        it.hold = hold;
        sb_q.push_back(it);
        n_push++;
    endfunction

    function automatic void push_done();
        sb_item_t it;
        it.tup = {2'b00, 3'b001, 3'(DEPTH - 1)};
        it.hold = 0;
        sb_q.push_back(it);
        n_push++;
    endfunction

    // Output monitor: every change pops the next expected tuple; the tuple it
    // replaces must have been held for its expected number of clocks.
    always @(negedge clk) begin
        logic [7:0] tup;
        sb_item_t   it;
        tup = {x2, x1, valid, busy, done, step_idx};
        if (!mon_en) begin
            last_tup = tup;
            held     = 0;
            held_exp = 0;
        end else if (tup !== last_tup) begin
            if (held_exp != 0) chk("hold_len", 32'(held), 32'(held_exp));
            if (sb_q.size() == 0) begin
                chk("unexpected_change", 32'(tup), 32'(last_tup));
                held_exp = 0;
            end else begin
                it = sb_q.pop_front();
                chk("out_tuple", 32'(tup), 32'(it.tup));
                held_exp = it.hold;
                n_pop++;
            end
            held     = 1;
            last_tup = tup;
        end else begin
            held++;
        end
    end

    task automatic press(input int n);
        start = 1'b1;
        repeat (n) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic zpulse();
        z_in = 1'b1;
        repeat (2) @(negedge clk);
        z_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pop(input int target, input int budget, input string tag);
        int b;
        b = 0;
        while (n_pop < target && b < budget) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (n_pop < target) chk(tag, 32'(n_pop), 32'(target));
    endtask

    initial begin
        int cnt;
        int r0;

        sys_rst_n = 1'b0;
        start     = 1'b0;
        mode_loop = 1'b0;
        z_in      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({x2, x1, valid, busy, done, step_idx}), 32'd0);
        chk("rst_zcount", 32'(z_count), 32'd0);
        sys_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("idle_status", 32'({done, busy, valid}), 32'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // Single pass: entries 00,01,10,11 each STEP_DIV clocks, then DONE.
        for (int i = 0; i < int'(DEPTH); i++) push_run(i, STEP_DIV);
        push_done();
        start = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 64);
        start = 1'b0;
        chk("start_latency", 32'(cnt), 32'(START_LAT + 1));
        wait_pop(n_push, 100, "single_pass_timeout");
        repeat (2) @(negedge clk);
        chk("single_done", 32'({done, busy, valid}), 32'b100);
        chk("single_zcount", 32'(z_count), 32'd0);

        // Loop mode with a restart two clocks into step 2 of the second pass.
        mode_loop = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) push_run(i, STEP_DIV);
        push_run(0, STEP_DIV);
        push_run(1, STEP_DIV);
        push_run(2, 2);
        r0 = n_push;
        for (int p = 0; p < LOOP_PASSES; p++)
            for (int i = 0; i < int'(DEPTH); i++) push_run(i, STEP_DIV);
        push_done();

        press(PRESS);
        repeat (14 - PRESS) @(negedge clk);
        repeat (2) zpulse();
        repeat (4) @(negedge clk);
        chk("zcount_before_restart", 32'(z_count), 32'd2);
        press(PRESS);
        wait_pop(r0 + 1, 64, "restart_timeout");
        chk("zcount_after_restart", 32'(z_count), 32'd0);

        // 300 z pulses while looping: count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            zpulse();
            if (i == 99) begin
                repeat (2) @(negedge clk);
                chk("zcount_100", 32'(z_count), 32'd100);
            end
        end
        wait_pop(r0 + 4 * (LOOP_PASSES - 1) + 1, 2000, "last_pass_timeout");
        mode_loop = 1'b0;
        wait_pop(n_push, 64, "loop_end_timeout");
        repeat (2) @(negedge clk);
        chk("loop_done", 32'({done, busy, valid}), 32'b100);
        chk("zcount_saturated", 32'(z_count), 32'd255);
        repeat (2) zpulse();
        repeat (4) @(negedge clk);
        chk("zcount_hold_done", 32'(z_count), 32'd255);

        // New start clears the count; then an asynchronous reset mid-run.
        push_run(0, STEP_DIV);
        push_run(1, 0);
        press(PRESS);
        wait_pop(n_push - 1, 64, "clear_start_timeout");
        chk("zcount_cleared", 32'(z_count), 32'd0);
        zpulse();
        wait_pop(n_push, 16, "entry1_timeout");
        chk("zcount_run", 32'(z_count), 32'd1);
        mon_en = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_outputs", 32'({x2, x1, valid, busy, done, step_idx}), 32'd0);
        chk("arst_zcount", 32'(z_count), 32'd0);
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", 32'({done, busy, valid}), 32'd0);
        chk("post_rst_idx", 32'(step_idx), 32'd0);
        repeat (2) zpulse();
        repeat (4) @(negedge clk);
        chk("zcount_idle", 32'(z_count), 32'd0);

`ifdef SEQ_GEN_DEBOUNCE_EN
        // Short glitch is filtered; a long press starts after the debounce window.
        press(5);
        repeat (20) @(negedge clk);
        chk("glitch_no_run", 32'(busy), 32'd0);
        start = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 64);
        start = 1'b0;
        chk("debounce_latency", 32'(cnt), 32'(START_LAT + 1));
`else
        // Without debounce a one-clock blip is a full start.
        start = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
        end while (!valid && cnt < 64);
        chk("blip_latency", 32'(cnt), 32'(START_LAT + 1));
`endif
        chk("run_entry0", 32'({x2, x1, step_idx}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
